// File: rtl/bin2bcd_pipe_param.sv
// bin2bcd_pipe_param: parametrised, fully pipelined binary-to-BCD converter
// (double dabble) with valid/ready handshake on both sides and a global stall.
// Stage 0 registers sign and magnitude. It is followed by S shift stages,
// each of which processes BPS magnitude bits. The last shift stage is the
// output register.
// Optional feature: define BIN2BCD_LZB_EN for leading-zero blanking. This
// blanks leading digits to 4'hF and adds the ndig output port.
module bin2bcd_pipe_param #(
  parameter int BIN_W = 11,
  parameter int NDIG  = 4,
  parameter int BPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin,
  input  logic             bin_sgn,
  input  logic             bin_vld,
  output logic             bin_rdy,
  output logic [4*NDIG:0]  bcd,
  output logic             bcd_vld,
  input  logic             bcd_rdy
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [$clog2(NDIG+1)-1:0] ndig
`endif
);

  localparam int DW      = 4 * NDIG;
  localparam int S       = (BIN_W + BPS - 1) / BPS;
  localparam int LAST_NB = BIN_W - (S - 1) * BPS;

  logic             adv;
  logic [S:0]       vld_q;
  logic [S:0]       sgn_q;
  logic [BIN_W-1:0] mag_q [0:S-1];
  logic [DW-1:0]    dig_q [1:S];
  logic [DW-1:0]    dig_d [1:S];
  logic [DW-1:0]    dig_out;
  logic [BIN_W-1:0] mag_in;
  logic             sgn_in;

  // nb double-dabble iterations (nb <= BPS): add 3 to every digit >= 5,
  // then shift the magnitude MSB into digit[0].
  function automatic logic [DW-1:0] dd_iter(input logic [DW-1:0] d_in,
                                            input logic [BIN_W-1:0] m_in,
                                            input int nb);
    logic [DW-1:0]    d;
    logic [BIN_W-1:0] m;
    d = d_in;
    m = m_in;
    for (int i = 0; i < BPS; i++) begin
      if (i < nb) begin
        for (int j = 0; j < NDIG; j++) begin
          if (d[4*j +: 4] >= 4'd5) d[4*j +: 4] = d[4*j +: 4] + 4'd3;
        end
        d = {d[DW-2:0], m[BIN_W-1]};
        m = {m[BIN_W-2:0], 1'b0};
      end
    end
    return d;
  endfunction

  // Global stall: everything moves only when the output slot is free or being taken.
  assign adv     = bcd_rdy | ~bcd_vld;
  assign bin_rdy = adv;
  assign bcd_vld = vld_q[S];
  assign bcd     = {sgn_q[S], dig_q[S]};

  // Sign and magnitude of the incoming sample. The most negative value maps
  // to magnitude 2^(BIN_W-1), which still fits in BIN_W unsigned bits.
  always_comb begin
    sgn_in = bin_sgn & bin[BIN_W-1];
    mag_in = sgn_in ? -bin : bin;
  end

  // Next-state digits for every shift stage. Stage 1 starts from all-zero digits.
  always_comb begin
    dig_d[1] = dd_iter({DW{1'b0}}, mag_q[0], (S == 1) ? LAST_NB : BPS);
    for (int k = 2; k <= S; k++) begin
      dig_d[k] = dd_iter(dig_q[k-1], mag_q[k-1], (k == S) ? LAST_NB : BPS);
    end
  end

`ifdef BIN2BCD_LZB_EN
  int nd_calc;

  // Blank digits above the most significant nonzero digit. digit[0] always survives.
  always_comb begin
    nd_calc = 1;
    for (int j = 1; j < NDIG; j++) begin
      if (dig_d[S][4*j +: 4] != 4'd0) nd_calc = j + 1;
    end
    dig_out = dig_d[S];
    for (int j = 1; j < NDIG; j++) begin
      if (j >= nd_calc) dig_out[4*j +: 4] = 4'hF;
    end
  end
`else
  // Without blanking the final stage passes its digits straight through.
  always_comb dig_out = dig_d[S];
`endif

  // Pipeline registers: advance together on adv, clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sgn_q <= '0;
      for (int k = 0; k < S; k++) mag_q[k] <= '0;
      for (int k = 1; k <= S; k++) dig_q[k] <= '0;
`ifdef BIN2BCD_LZB_EN
      ndig <= '0;
`endif
    end else if (adv) begin
      vld_q    <= {vld_q[S-1:0], bin_vld};
      sgn_q    <= {sgn_q[S-1:0], sgn_in};
      mag_q[0] <= mag_in;
      for (int k = 1; k < S; k++) mag_q[k] <= mag_q[k-1] << BPS;
      for (int k = 1; k <= S; k++) dig_q[k] <= (k == S) ? dig_out : dig_d[k];
`ifdef BIN2BCD_LZB_EN
      ndig <= ($clog2(NDIG+1))'(nd_calc);
`endif
    end
  end

endmodule
